// File: rtl/fdiv_arbiter.sv
// -----------------------------------------------------------------------------
// fdiv_arbiter
//   Shares one combinational floating-point divider between NREQ requesters.
//   A round-robin arbiter issues at most one division per cycle. The quotient
//   travels through LAT register stages into an in-order, first-word
//   fall-through response FIFO tagged with the requester index. A credit
//   counter (stages in flight + FIFO occupancy) keeps the FIFO from ever
//   overflowing, so the pipeline never stalls.
//
//   Optional feature macro: FDIV_DIVZERO_EN
//     defined   : a divisor whose exponent field is 8'h00 yields resp_dz=1,
//                 resp_y = signed infinity and resp_ovf=0.
//     undefined : resp_dz is always 0 and resp_y/resp_ovf are the raw
//                 divider outputs.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active high
//   req_valid   per-requester request valid
//   req_ready   per-requester accept (one-hot or zero, combinational)
//   req_x1      dividends, requester i at [32*i+31:32*i]
//   req_x2      divisors, same packing
//   resp_valid  FIFO head valid
//   resp_ready  consumer accepts head
//   resp_id     requester index of head (0 when resp_valid=0)
//   resp_y      quotient x1/x2          (0 when resp_valid=0)
//   resp_ovf    overflow flag           (0 when resp_valid=0)
//   resp_dz     divide-by-zero flag     (0 when resp_valid=0)
//   busy        any division in the pipeline or the FIFO
// -----------------------------------------------------------------------------
module fdiv_arbiter #(
   parameter int NREQ       = 4,
   parameter int LAT        = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [32*NREQ-1:0]      req_x1,
   input  logic [32*NREQ-1:0]      req_x2,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [$clog2(NREQ)-1:0] resp_id,
   output logic [31:0]             resp_y,
   output logic                    resp_ovf,
   output logic                    resp_dz,
   output logic                    busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int AW  = $clog2(FIFO_DEPTH);
   // entry layout: {dz, ovf, y[31:0], id}
   localparam int EW  = IDW + 34;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   // Returns {found, index} of the first set bit of v searching start, start+1, ...
   // The loop runs backwards so the final write is the nearest hit to start.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IDW-1:0]  start);
      int idx;
      rr_pick = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % NREQ;
         if (v[idx]) rr_pick = {1'b1, idx[IDW-1:0]};
         else        rr_pick = rr_pick;
      end
   endfunction

   // Divider returning {ovf, y}. The reciprocal-times-dividend product is
   // formed as a direct 24-bit mantissa quotient, truncated. A zero/denormal
   // divisor saturates to signed infinity with ovf, a zero/denormal dividend
   // gives signed zero, exponent underflow flushes to signed zero.
   function automatic logic [32:0] fdiv(input logic [31:0] a, input logic [31:0] b);
      logic              s;
      logic [23:0]       ma;
      logic [23:0]       mb;
      logic [24:0]       q;
      logic signed [9:0] ex;
      s  = a[31] ^ b[31];
      ma = {1'b1, a[22:0]};
      mb = {1'b1, b[22:0]};
      q  = 25'({ma, 24'h000000} / {24'h000000, mb});
      ex = 10'sd127 + $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
           - (q[24] ? 10'sd0 : 10'sd1);
      if (b[30:23] == 8'h00)      fdiv = {1'b1, s, 8'hFF, 23'h000000};
      else if (a[30:23] == 8'h00) fdiv = {1'b0, s, 31'h00000000};
      else if (ex >= 10'sd255)    fdiv = {1'b1, s, 8'hFF, 23'h000000};
      else if (ex <= 10'sd0)      fdiv = {1'b0, s, 31'h00000000};
      else if (q[24])             fdiv = {1'b0, s, ex[7:0], q[23:1]};
      else                        fdiv = {1'b0, s, ex[7:0], q[22:0]};
   endfunction

   logic [IDW-1:0]  rr_r;
   logic [AW:0]     cnt_r;
   logic [LAT-1:0]  st_v_r;
   logic [EW-1:0]   st_d_r [LAT];
   logic [EW-1:0]   mem_r  [FIFO_DEPTH];
   logic [AW:0]     wptr_r;
   logic [AW:0]     rptr_r;

   logic [IDW:0]    pick_s;
   logic [IDW-1:0]  grant_s;
   logic            any_s;
   logic            empty_s;
   logic            pop_s;
   logic            can_issue_s;
   logic            accept_s;
   logic [31:0]     x1_s;
   logic [31:0]     x2_s;
   logic [31:0]     y_s;
   logic            ovf_s;
   logic            dz_s;
   logic [EW-1:0]   head_s;

   assign pick_s   = rr_pick(req_valid, rr_r);
   assign any_s    = pick_s[IDW];
   assign grant_s  = pick_s[IDW-1:0];
   assign empty_s  = (wptr_r == rptr_r);
   assign pop_s    = ~empty_s & resp_ready;
   // A same-cycle pop frees a credit, so a full counter can still issue.
   assign can_issue_s = (cnt_r < DEPTH_C) | pop_s;
   assign accept_s = |(req_valid & req_ready);
   assign x1_s     = req_x1[32*grant_s +: 32];
   assign x2_s     = req_x2[32*grant_s +: 32];
   assign head_s   = mem_r[rptr_r[AW-1:0]];
   assign busy     = (|st_v_r) | ~empty_s;

   // Grant: one-hot on the round-robin winner when a credit is available.
   always_comb begin
      req_ready = '0;
      if (!rst && can_issue_s && any_s) req_ready[grant_s] = 1'b1;
      else                              req_ready = '0;
   end

   // Divider result for the granted operands, with optional divide-by-zero override.
   always_comb begin
      {ovf_s, y_s} = fdiv(x1_s, x2_s);
      dz_s         = 1'b0;
`ifdef FDIV_DIVZERO_EN
      if (x2_s[30:23] == 8'h00) begin
         dz_s  = 1'b1;
         ovf_s = 1'b0;
         y_s   = {x1_s[31] ^ x2_s[31], 8'hFF, 23'h000000};
      end else begin
         dz_s  = 1'b0;
      end
`endif
   end

   // Round-robin pointer and credit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_r  <= '0;
         cnt_r <= '0;
      end else begin
         if (accept_s)
            rr_r <= (grant_s == IDW'(NREQ - 1)) ? '0 : grant_s + 1'b1;
         case ({accept_s, pop_s})
            2'b10:   cnt_r <= cnt_r + 1'b1;
            2'b01:   cnt_r <= cnt_r - 1'b1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Result pipeline: stage 0 captures the divider, later stages shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_v_r <= '0;
         for (int j = 0; j < LAT; j++) st_d_r[j] <= '0;
      end else begin
         st_v_r[0] <= accept_s;
         st_d_r[0] <= {dz_s, ovf_s, y_s, grant_s};
         for (int j = 1; j < LAT; j++) begin
            st_v_r[j] <= st_v_r[j-1];
            st_d_r[j] <= st_d_r[j-1];
         end
      end
   end

   // FIFO storage; credits guarantee a free slot whenever the last stage is valid.
   always_ff @(posedge clk) begin
      if (st_v_r[LAT-1]) mem_r[wptr_r[AW-1:0]] <= st_d_r[LAT-1];
   end

   // FIFO pointers with an extra wrap bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r <= '0;
         rptr_r <= '0;
      end else begin
         if (st_v_r[LAT-1]) wptr_r <= wptr_r + 1'b1;
         if (pop_s)         rptr_r <= rptr_r + 1'b1;
      end
   end

   // Head presentation, zeroed whenever nothing is valid.
   always_comb begin
      resp_valid = ~empty_s;
      if (resp_valid) {resp_dz, resp_ovf, resp_y, resp_id} = head_s;
      else            {resp_dz, resp_ovf, resp_y, resp_id} = '0;
   end

endmodule
